// File: rtl/pixel_sensor_model_pkg.sv
// PixelSensorConfig: shared configuration for the pixel sensor model.
//   pixel_state_t       - pixel FSM state encoding
//   DEFAULT_BITS        - default charge / ramp-count / LIGHT width
//   DEFAULT_DARK_PERIOD - default clk cycles per dark-current increment
package PixelSensorConfig;

    localparam int unsigned DEFAULT_BITS        = 8;
    localparam int unsigned DEFAULT_DARK_PERIOD = 16;

    typedef enum logic [2:0] {
        ST_ERASED     = 3'd0,
        ST_EXPOSING   = 3'd1,
        ST_HOLD       = 3'd2,
        ST_CONVERTING = 3'd3,
        ST_DONE       = 3'd4
    } pixel_state_t;

endpackage

// File: rtl/pixel_sensor_model_if.sv
// Pixel control/status bundle.
//   ERASE, EXPOSE, RAMP, LIGHT[BITS] : controller -> pixel
//   CMP, SATURATED, BUSY             : pixel -> controller
// modport master: controller side; modport slave: pixel side.
interface pixel_sensor_model_if
    import PixelSensorConfig::*;
#(
    parameter int unsigned BITS = DEFAULT_BITS
);
    logic            ERASE;
    logic            EXPOSE;
    logic            RAMP;
    logic [BITS-1:0] LIGHT;
    logic            CMP;
    logic            SATURATED;
    logic            BUSY;

    modport master (
        output ERASE, EXPOSE, RAMP, LIGHT,
        input  CMP, SATURATED, BUSY
    );

    modport slave (
        input  ERASE, EXPOSE, RAMP, LIGHT,
        output CMP, SATURATED, BUSY
    );
endinterface

// File: rtl/pixel_sensor_model_sat_counter.sv
// pixel_sat_counter: up-counter that sticks at all-ones.
//   clk     : clock
//   clr_i   : synchronous clear (priority over enable)
//   en_i    : count enable
//   count_o : current count
module pixel_sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count_o = count_q;
endmodule

// File: rtl/pixel_sensor_model.sv
// pixel_sensor_model: behavioural model of a single-slope ADC pixel.
//   clk   : sole clock
//   reset : synchronous active-high reset (also clears RAMP_q and dark divider)
//   px    : pixel_sensor_model_if.slave (ERASE/EXPOSE/RAMP/LIGHT in,
//           CMP/SATURATED/BUSY out)
// Optional feature: define PIXEL_SENSOR_DARK_CURRENT_EN to add a dark-current
// leak of +1 charge every DARK_PERIOD cycles in HOLD and CONVERTING.
module pixel_sensor_model
    import PixelSensorConfig::*;
#(
    parameter int unsigned BITS        = DEFAULT_BITS,
    parameter int unsigned DARK_PERIOD = DEFAULT_DARK_PERIOD
) (
    input  logic                 clk,
    input  logic                 reset,
    pixel_sensor_model_if.slave  px
);
    localparam logic [BITS-1:0] MAX = '1;

    pixel_state_t    state_q, state_d;
    logic [BITS-1:0] charge_q, charge_d;
    logic            cmp_q, cmp_d;
    logic            sat_q, sat_d;
    logic            ramp_q;
    logic [BITS-1:0] ramp_count;

    logic            clear;
    logic            ramp_edge;
    logic            ramp_accept;
    logic            integrate;
    logic            trip;
    logic            dark_tick;
    logic [BITS-1:0] threshold;
    logic [BITS:0]   expose_sum;

    // reset is a superset of ERASE for everything held in _q registers.
    assign clear     = reset | px.ERASE;
    assign ramp_edge = px.RAMP & ~ramp_q;

    // The cycle that leaves ERASED/HOLD already integrates, so N cycles of
    // EXPOSE=1 accumulate N*LIGHT.
    assign integrate = px.EXPOSE &
                       ((state_q == ST_ERASED) || (state_q == ST_HOLD) ||
                        (state_q == ST_EXPOSING));

    assign ramp_accept = ramp_edge & ~px.EXPOSE & ~clear &
                         ((state_q == ST_ERASED) || (state_q == ST_HOLD) ||
                          (state_q == ST_CONVERTING));

    // Compare uses the pre-increment count, so threshold T trips on edge T+1.
    assign threshold  = MAX - charge_q;
    assign trip       = ramp_accept & (ramp_count >= threshold);
    assign expose_sum = {1'b0, charge_q} + {1'b0, px.LIGHT};

    pixel_sat_counter #(
        .WIDTH (BITS)
    ) u_ramp_count (
        .clk     (clk),
        .clr_i   (clear),
        .en_i    (ramp_accept),
        .count_o (ramp_count)
    );

`ifdef PIXEL_SENSOR_DARK_CURRENT_EN
    localparam int unsigned DIV_W = 16;

    logic [DIV_W-1:0] div_count;
    logic             div_en;
    logic             div_clr;
    logic             hold_entry;

    assign hold_entry = (state_q == ST_EXPOSING) && (state_d == ST_HOLD);
    assign div_en     = (state_q == ST_HOLD) || (state_q == ST_CONVERTING);
    assign dark_tick  = div_en && (div_count == 16'(DARK_PERIOD - 1));
    // Clearing on the tick itself makes the divider a modulo-DARK_PERIOD counter.
    assign div_clr    = clear | hold_entry | dark_tick;

    pixel_sat_counter #(
        .WIDTH (DIV_W)
    ) u_dark_div (
        .clk     (clk),
        .clr_i   (div_clr),
        .en_i    (div_en),
        .count_o (div_count)
    );
`else
    logic unused_dark_period;

    assign dark_tick          = 1'b0;
    assign unused_dark_period = ^DARK_PERIOD;
`endif

    always_comb begin
        state_d  = state_q;
        charge_d = charge_q;
        cmp_d    = cmp_q | trip;
        sat_d    = sat_q;

        if (integrate) begin
            if (expose_sum[BITS]) begin
                charge_d = MAX;
                sat_d    = 1'b1;
            end else begin
                charge_d = expose_sum[BITS-1:0];
            end
        end else if (dark_tick && (charge_q != MAX)) begin
            charge_d = charge_q + 1'b1;
        end

        case (state_q)
            ST_ERASED, ST_HOLD: begin
                if (px.EXPOSE) begin
                    state_d = ST_EXPOSING;
                end else if (ramp_edge) begin
                    state_d = trip ? ST_DONE : ST_CONVERTING;
                end
            end
            ST_EXPOSING: begin
                if (!px.EXPOSE) begin
                    state_d = ST_HOLD;
                end
            end
            ST_CONVERTING: begin
                if (trip) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_ERASED;
            end
        endcase

        if (clear) begin
            state_d  = ST_ERASED;
            charge_d = '0;
            cmp_d    = 1'b0;
            sat_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q  <= state_d;
        charge_q <= charge_d;
        cmp_q    <= cmp_d;
        sat_q    <= sat_d;
        if (reset) begin
            ramp_q <= 1'b0;
        end else begin
            ramp_q <= px.RAMP;
        end
    end

    assign px.CMP       = cmp_q;
    assign px.SATURATED = sat_q;
    assign px.BUSY      = (state_q == ST_EXPOSING) || (state_q == ST_CONVERTING);
endmodule

// File: tb/tb_pixel_sensor_model.sv
// Directed self-checking bench for pixel_sensor_model (BITS=8, DARK_PERIOD=16).
module tb_pixel_sensor_model;
    import PixelSensorConfig::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic early;

    pixel_sensor_model_if #(.BITS(8)) px ();

    pixel_sensor_model #(
        .BITS        (8),
        .DARK_PERIOD (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .px    (px)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ramp_pulse();
        px.RAMP = 1'b1;
        tick();
        px.RAMP = 1'b0;
        tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        px.ERASE  = 1'b0;
        px.EXPOSE = 1'b0;
        px.RAMP   = 1'b0;
        px.LIGHT  = '0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_cmp", 32'(px.CMP), 0);
        check("rst_sat", 32'(px.SATURATED), 0);
        check("rst_busy", 32'(px.BUSY), 0);
        check("rst_state", 32'(dut.state_q), 32'(ST_ERASED));
        check("rst_charge", 32'(dut.charge_q), 0);

        // 5 cycles of LIGHT=10 -> 50; threshold 205 trips on edge 206.
        px.EXPOSE = 1'b1;
        px.LIGHT  = 8'd10;
        tick();
        check("t1_state_exposing", 32'(dut.state_q), 32'(ST_EXPOSING));
        check("t1_charge_first", 32'(dut.charge_q), 10);
        repeat (4) tick();
        check("t1_busy_exposing", 32'(px.BUSY), 1);
        px.EXPOSE = 1'b0;
        px.LIGHT  = '0;
        tick();
        check("t1_state_hold", 32'(dut.state_q), 32'(ST_HOLD));
        check("t1_charge", 32'(dut.charge_q), 50);
        check("t1_busy_hold", 32'(px.BUSY), 0);
        early = 1'b0;
        for (int i = 0; i < 205; i++) begin
            ramp_pulse();
            early = early | px.CMP;
        end
        check("t1_no_early_cmp", 32'(early), 0);
        check("t1_count205", 32'(dut.ramp_count), 205);
        check("t1_state_conv", 32'(dut.state_q), 32'(ST_CONVERTING));
        check("t1_busy_conv", 32'(px.BUSY), 1);
        px.RAMP = 1'b1;
        tick();
        check("t1_cmp_edge206", 32'(px.CMP), 1);
        check("t1_state_done", 32'(dut.state_q), 32'(ST_DONE));
        check("t1_sat", 32'(px.SATURATED), 0);
        px.RAMP = 1'b0;
        tick();

        // LIGHT=200 for 2 cycles clips at 255; first edge trips.
        px.ERASE = 1'b1;
        tick();
        px.ERASE = 1'b0;
        check("t2_erase_cmp", 32'(px.CMP), 0);
        check("t2_erase_charge", 32'(dut.charge_q), 0);
        px.EXPOSE = 1'b1;
        px.LIGHT  = 8'd200;
        repeat (2) tick();
        px.EXPOSE = 1'b0;
        px.LIGHT  = '0;
        tick();
        check("t2_charge_clip", 32'(dut.charge_q), 255);
        check("t2_sat", 32'(px.SATURATED), 1);
        check("t2_cmp_before", 32'(px.CMP), 0);
        px.RAMP = 1'b1;
        tick();
        check("t2_cmp_edge1", 32'(px.CMP), 1);
        px.RAMP = 1'b0;
        tick();

        // No exposure: trips on edge 256, count saturates at 255.
        px.ERASE = 1'b1;
        tick();
        px.ERASE = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 255; i++) begin
            ramp_pulse();
            early = early | px.CMP;
        end
        check("t3_no_early_cmp", 32'(early), 0);
        check("t3_count255", 32'(dut.ramp_count), 255);
        px.RAMP = 1'b1;
        tick();
        check("t3_cmp_edge256", 32'(px.CMP), 1);
        px.RAMP = 1'b0;
        tick();
        for (int i = 0; i < 44; i++) begin
            ramp_pulse();
        end
        check("t3_count_held", 32'(dut.ramp_count), 255);
        check("t3_cmp_sticky", 32'(px.CMP), 1);
        check("t3_state_done", 32'(dut.state_q), 32'(ST_DONE));

        // ERASE beats a simultaneous ramp edge; EXPOSE ignored in CONVERTING.
        px.ERASE = 1'b1;
        tick();
        px.ERASE = 1'b0;
        for (int i = 0; i < 100; i++) begin
            ramp_pulse();
        end
        check("t4_count100", 32'(dut.ramp_count), 100);
        px.EXPOSE = 1'b1;
        px.LIGHT  = 8'd50;
        tick();
        check("t4_expose_ignored_state", 32'(dut.state_q), 32'(ST_CONVERTING));
        check("t4_expose_ignored_charge", 32'(dut.charge_q), 0);
        px.EXPOSE = 1'b0;
        px.LIGHT  = '0;
        px.RAMP   = 1'b1;
        px.ERASE  = 1'b1;
        tick();
        check("t4_erase_cmp", 32'(px.CMP), 0);
        check("t4_erase_count", 32'(dut.ramp_count), 0);
        check("t4_erase_state", 32'(dut.state_q), 32'(ST_ERASED));
        check("t4_erase_busy", 32'(px.BUSY), 0);
        px.ERASE = 1'b0;
        px.RAMP  = 1'b0;
        tick();

        // Ramp edges during exposure are ignored; reset mid-exposure.
        px.EXPOSE = 1'b1;
        px.LIGHT  = 8'd1;
        tick();
        for (int i = 0; i < 3; i++) begin
            ramp_pulse();
        end
        check("t5_count_unchanged", 32'(dut.ramp_count), 0);
        check("t5_state_exposing", 32'(dut.state_q), 32'(ST_EXPOSING));
        check("t5_charge", 32'(dut.charge_q), 7);
        reset = 1'b1;
        tick();
        check("t5_rst_state", 32'(dut.state_q), 32'(ST_ERASED));
        check("t5_rst_charge", 32'(dut.charge_q), 0);
        check("t5_rst_busy", 32'(px.BUSY), 0);
        check("t5_rst_cmp", 32'(px.CMP), 0);
        check("t5_rst_sat", 32'(px.SATURATED), 0);
        reset     = 1'b0;
        px.EXPOSE = 1'b0;
        px.LIGHT  = '0;
        tick();

        // Charge 50 held for 160 cycles: +10 only with dark current enabled.
        px.EXPOSE = 1'b1;
        px.LIGHT  = 8'd10;
        repeat (5) tick();
        px.EXPOSE = 1'b0;
        px.LIGHT  = '0;
        tick();
        check("t6_charge_start", 32'(dut.charge_q), 50);
        repeat (160) tick();
`ifdef PIXEL_SENSOR_DARK_CURRENT_EN
        check("t6_charge_dark", 32'(dut.charge_q), 60);
`else
        check("t6_charge_dark", 32'(dut.charge_q), 50);
`endif
        check("t6_sat", 32'(px.SATURATED), 0);
        check("t6_state_hold", 32'(dut.state_q), 32'(ST_HOLD));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
